// File: rtl/user_id_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | user_id_pkg: shared states, defaults and frame length for user_id_reader |
// | Build option USER_ID_PARITY_EN appends an even-parity bit to each frame.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package user_id_pkg;

    localparam int USER_ID_WIDTH_DEFAULT = 32;

    typedef enum logic [0:0] {
        H_IDLE = 1'b0,
        H_ACK  = 1'b1
    } hs_state_t;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } sh_state_t;

    function automatic int frame_bits(input int id_width);
`ifdef USER_ID_PARITY_EN
        return id_width + 1;
`else
        return id_width;
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/user_id_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | user_id_shifter: MSB-first strobed serialiser of the snapshot word       |
// | Build option USER_ID_PARITY_EN appends an even-parity bit after the LSB.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module user_id_shifter
    import user_id_pkg::*;
#(
    parameter int ID_WIDTH = USER_ID_WIDTH_DEFAULT,
    parameter int CLK_DIV  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ID_WIDTH-1:0] id_q,
    input  logic                tx_start,
    output logic                tx_busy,
    output logic                tx_data,
    output logic                tx_strobe,
    output logic                tx_last
);

    localparam int c_frame_bits = frame_bits(ID_WIDTH);
    localparam int c_bit_w      = $clog2(c_frame_bits + 1);
    localparam int c_div_w      = $clog2(CLK_DIV + 1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(c_frame_bits - 1);
    localparam logic [c_div_w-1:0] c_div_max  = c_div_w'(CLK_DIV - 1);

    sh_state_t                 r_state;
    sh_state_t                 w_state_next;
    logic [c_frame_bits-1:0]   r_shreg;
    logic [c_frame_bits-1:0]   w_load_word;
    logic [c_bit_w-1:0]        r_bit_cnt;
    logic [c_div_w-1:0]        r_div_cnt;
    logic                      r_busy;
    logic                      r_strobe;
    logic                      r_last;
    logic                      w_load;
    logic                      w_bit_end;
    logic                      w_frame_end;

`ifdef USER_ID_PARITY_EN
    assign w_load_word = {id_q, ^id_q};
`else
    assign w_load_word = id_q;
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_bit_end    = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (tx_start) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_div_cnt == c_div_max) begin
                    w_bit_end = 1'b1;
                    if (r_bit_cnt == c_last_bit) begin
                        w_frame_end  = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Shift register is cleared at frame end so tx_data idles low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_busy    <= 1'b0;
            r_strobe  <= 1'b0;
            r_last    <= 1'b0;
        end else if (w_load) begin
            r_shreg   <= w_load_word;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_busy    <= 1'b1;
            r_strobe  <= 1'b1;
            r_last    <= (c_last_bit == '0);
        end else if (w_frame_end) begin
            r_shreg   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_busy    <= 1'b0;
            r_strobe  <= 1'b0;
            r_last    <= 1'b0;
        end else if (w_bit_end) begin
            r_shreg   <= r_shreg << 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
            r_div_cnt <= '0;
            r_strobe  <= 1'b1;
            r_last    <= ((r_bit_cnt + 1'b1) == c_last_bit);
        end else if (r_state == S_SHIFT) begin
            r_div_cnt <= r_div_cnt + 1'b1;
            r_strobe  <= 1'b0;
        end
    end

    assign tx_busy   = r_busy;
    assign tx_data   = r_shreg[c_frame_bits-1];
    assign tx_strobe = r_strobe;
    assign tx_last   = r_last;

endmodule
`default_nettype wire

// File: rtl/user_id_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | user_id_reader: req/ack snapshot of mask_rev, byte read and serial out   |
// | Build option USER_ID_PARITY_EN adds id_parity and a parity frame bit.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module user_id_reader
    import user_id_pkg::*;
#(
    parameter int ID_WIDTH = USER_ID_WIDTH_DEFAULT,
    parameter int CLK_DIV  = 4
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rstn_i,
    input  logic [ID_WIDTH-1:0]           mask_rev,
    input  logic                          rd_req,
    output logic                          rd_ack,
    output logic [ID_WIDTH-1:0]           id_value,
    input  logic [$clog2(ID_WIDTH/8)-1:0] byte_sel,
    output logic [7:0]                    id_byte,
`ifdef USER_ID_PARITY_EN
    output logic                          id_parity,
`endif
    input  logic                          tx_start,
    output logic                          tx_busy,
    output logic                          tx_data,
    output logic                          tx_strobe,
    output logic                          tx_last
);

    localparam int c_bytes = ID_WIDTH / 8;
    localparam int c_sel_w = $clog2(c_bytes);

    hs_state_t             r_hs_state;
    hs_state_t             w_hs_next;
    logic                  w_capture;
    logic [ID_WIDTH-1:0]   id_q;

    always_comb begin
        w_hs_next = r_hs_state;
        w_capture = 1'b0;
        case (r_hs_state)
            H_IDLE: begin
                if (rd_req) begin
                    w_hs_next = H_ACK;
                    w_capture = 1'b1;
                end
            end
            H_ACK: begin
                if (!rd_req) begin
                    w_hs_next = H_IDLE;
                end
            end
            default: w_hs_next = H_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            r_hs_state <= H_IDLE;
            id_q       <= '0;
        end else begin
            r_hs_state <= w_hs_next;
            if (w_capture) begin
                id_q <= mask_rev;
            end
        end
    end

    assign rd_ack   = (r_hs_state == H_ACK);
    assign id_value = id_q;

    // Explicit mux keeps out-of-range selects at zero for non-power-of-two widths.
    always_comb begin
        id_byte = 8'h00;
        for (int b = 0; b < c_bytes; b++) begin
            if (byte_sel == c_sel_w'(b)) begin
                id_byte = id_q[8*b +: 8];
            end
        end
    end

`ifdef USER_ID_PARITY_EN
    assign id_parity = ^id_q;
`endif

    user_id_shifter #(
        .ID_WIDTH (ID_WIDTH),
        .CLK_DIV  (CLK_DIV)
    ) u_shifter (
        .clk       (wb_clk_i),
        .rst_n     (wb_rstn_i),
        .id_q      (id_q),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .tx_last   (tx_last)
    );

endmodule
`default_nettype wire

// File: tb/tb_user_id_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_user_id_reader: self-checking bench with a frame-level reference model |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_user_id_reader;
    import user_id_pkg::*;

    localparam int W  = 32;
    localparam int CD = 4;
    localparam int FB = frame_bits(W);
    localparam int FL = FB * CD;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] mask_rev;
    logic         rd_req;
    logic         rd_ack;
    logic [W-1:0] id_value;
    logic [1:0]   byte_sel;
    logic [7:0]   id_byte;
    logic         id_parity;
    logic         tx_start;
    logic         tx_busy;
    logic         tx_data;
    logic         tx_strobe;
    logic         tx_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

`ifndef USER_ID_PARITY_EN
    assign id_parity = 1'b0;
`endif

    user_id_reader #(
        .ID_WIDTH (W),
        .CLK_DIV  (CD)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rstn_i (rstn),
        .mask_rev  (mask_rev),
        .rd_req    (rd_req),
        .rd_ack    (rd_ack),
        .id_value  (id_value),
        .byte_sel  (byte_sel),
        .id_byte   (id_byte),
`ifdef USER_ID_PARITY_EN
        .id_parity (id_parity),
`endif
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_strobe (tx_strobe),
        .tx_last   (tx_last)
    );

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: snapshot word, ack level, and a frame as a bit list plus elapsed clocks.
    logic [W-1:0] m_id;
    logic         m_ack;
    logic         m_active;
    int           m_t;
    logic         m_frame [FB];

    function automatic logic frame_bit(input logic [W-1:0] id, input int i);
        if (i < W) return id[W-1-i];
        return ^id;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_id     <= '0;
            m_ack    <= 1'b0;
            m_active <= 1'b0;
            m_t      <= 0;
        end else begin
            if (m_active) begin
                if (m_t == FL - 1) m_active <= 1'b0;
                else m_t <= m_t + 1;
            end else if (tx_start) begin
                m_active <= 1'b1;
                m_t      <= 0;
                for (int i = 0; i < FB; i++) m_frame[i] <= frame_bit(m_id, i);
            end
            if (!m_ack && rd_req) begin
                m_id  <= mask_rev;
                m_ack <= 1'b1;
            end else if (m_ack && !rd_req) begin
                m_ack <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic e_data, e_strobe, e_last;
        e_data   = m_active ? m_frame[m_t / CD] : 1'b0;
        e_strobe = m_active && (m_t % CD == 0);
        e_last   = m_active && (m_t / CD == FB - 1);
        chk("m_rd_ack",   W'(rd_ack),    W'(m_ack));
        chk("m_id_value", id_value,      m_id);
        chk("m_id_byte",  W'(id_byte),   W'(m_id[8*byte_sel +: 8]));
        chk("m_tx_busy",  W'(tx_busy),   W'(m_active));
        chk("m_tx_data",  W'(tx_data),   W'(e_data));
        chk("m_tx_strobe", W'(tx_strobe), W'(e_strobe));
        chk("m_tx_last",  W'(tx_last),   W'(e_last));
`ifdef USER_ID_PARITY_EN
        chk("m_id_parity", W'(id_parity), W'(^m_id));
`endif
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Runs one frame from a tx_start pulse; optionally injects a restart and a capture mid-frame.
    task automatic run_frame(input bit inject, output logic [63:0] acc,
                             output int busy_n, output int strobe_n, output int last_n);
        int guard;
        acc = '0; busy_n = 0; strobe_n = 0; last_n = 0; guard = 0;
        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        while (tx_busy && guard < 1000) begin
            busy_n++;
            if (tx_strobe) begin
                strobe_n++;
                acc = {acc[62:0], tx_data};
            end
            if (tx_last) last_n++;
            if (inject && busy_n == 30) begin
                tx_start = 1'b1;
                rd_req   = 1'b1;
            end
            if (inject && busy_n == 31) tx_start = 1'b0;
            if (inject && busy_n == 34) rd_req = 1'b0;
            step();
            guard++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] id_ref;
        logic [7:0]   eb [4];
        logic [63:0]  acc;
        int           bn, sn, ln;

        id_ref = 32'hA5C3_0F12;
        eb = '{8'h12, 8'h0F, 8'hC3, 8'hA5};
        mask_rev = id_ref;
        rd_req   = 1'b0;
        tx_start = 1'b0;
        byte_sel = 2'd0;
        rstn     = 1'b0;
        repeat (3) step();
        rstn = 1'b1;
        repeat (3) step();
        chk("rst_id_value", id_value, '0);
        chk("rst_rd_ack",   W'(rd_ack), '0);
        chk("rst_tx_busy",  W'({tx_busy, tx_data, tx_strobe, tx_last}), '0);

        rd_req = 1'b1;
        step();
        chk("cap_id_value", id_value, id_ref);
        chk("cap_rd_ack",   W'(rd_ack), 1);
        mask_rev = 32'h1234_5678;
        repeat (19) step();
        chk("hold_one_capture", id_value, id_ref);
        rd_req = 1'b0;
        step();
        chk("ack_drop", W'(rd_ack), 0);

        for (int b = 0; b < 4; b++) begin
            byte_sel = 2'(b);
            #1;
            chk("id_byte_lit", W'(id_byte), W'(eb[b]));
            step();
        end

        run_frame(1'b0, acc, bn, sn, ln);
        chk("frame_busy_clocks", W'(bn), W'(FL));
        chk("frame_strobes",     W'(sn), W'(FB));
        chk("frame_last_clocks", W'(ln), W'(CD));
`ifdef USER_ID_PARITY_EN
        chk("frame_word",   acc[W:1], id_ref);
        chk("frame_parity", W'(acc[0]), W'(^id_ref));
`else
        chk("frame_word", acc[W-1:0], id_ref);
`endif

        mask_rev = 32'h0000_0001;
        run_frame(1'b1, acc, bn, sn, ln);
        chk("mid_busy_clocks", W'(bn), W'(FL));
        chk("mid_strobes",     W'(sn), W'(FB));
`ifdef USER_ID_PARITY_EN
        chk("mid_word", acc[W:1], id_ref);
`else
        chk("mid_word", acc[W-1:0], id_ref);
`endif
        chk("mid_id_value", id_value, 32'h0000_0001);
        step();
        chk("mid_no_restart", W'(tx_busy), 0);

        tx_start = 1'b1;
        step();
        tx_start = 1'b0;
        repeat (40) step();
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_tx", W'({tx_busy, tx_data, tx_strobe, tx_last}), '0);
        chk("arst_id", id_value, '0);
        chk("arst_ack", W'(rd_ack), '0);
        step();
        step();
        rstn = 1'b1;
        sn = 0; bn = 0;
        repeat (20) begin
            if (tx_strobe) sn++;
            if (tx_busy) bn++;
            step();
        end
        chk("post_rst_strobes", W'(sn), 0);
        chk("post_rst_busy",    W'(bn), 0);

        repeat (600) begin
            if ($urandom_range(0, 2) == 0) rd_req = ~rd_req;
            tx_start = ($urandom_range(0, 15) == 0);
            mask_rev = $urandom;
            byte_sel = 2'($urandom_range(0, 3));
            step();
        end
        tx_start = 1'b0;
        rd_req   = 1'b0;
        repeat (2) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
